// File: rtl/control_unity_if.sv
// Opcode-to-control bundle between the instruction fetch side and the main decoder.
// The fetch side drives opcode through the master modport; the decoder returns the control signals.
interface control_unity_if;
  logic [3:0] opcode;
  logic       RegDst;
  logic       Branch;
  logic       MemRead;
  logic       MemtoReg;
  logic [1:0] ALUOp;
  logic       MemWrite;
  logic       ALUSrc;
  logic       RegWrite;

  modport master (
    output opcode,
    input  RegDst, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite
  );

  modport slave (
    input  opcode,
    output RegDst, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite
  );
endinterface

// File: rtl/control_unity.sv
// Main decoder of the 16-bit processor: opcode in, registered datapath controls out.
// Controls appear one rising edge after the opcode; there is no instruction history.
module control_unity (
  input  logic            clock,
  input  logic            reset,
  control_unity_if.slave  bus
);

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluFn  = 2'b10;
  localparam logic [1:0] AluLog = 2'b11;

  ctrl_t w_ctrl;
  ctrl_t r_ctrl;

  // Reserved and unknown opcodes fall through to the all-zero NOP pattern.
  always_comb begin
    w_ctrl = '0;
    case (bus.opcode)
      4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.alu_op    = AluFn;
        w_ctrl.reg_write = 1'b1;
      end
      4'b0110: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = AluAdd;
        w_ctrl.reg_write = 1'b1;
      end
      4'b0111: begin
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.alu_op     = AluAdd;
        w_ctrl.reg_write  = 1'b1;
      end
      4'b1000: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_op    = AluAdd;
      end
      4'b1001: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = AluSub;
      end
      4'b1010, 4'b1011: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = AluLog;
        w_ctrl.reg_write = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ctrl <= '0;
    end else begin
      r_ctrl <= w_ctrl;
    end
  end

  assign bus.RegDst   = r_ctrl.reg_dst;
  assign bus.Branch   = r_ctrl.branch;
  assign bus.MemRead  = r_ctrl.mem_read;
  assign bus.MemtoReg = r_ctrl.mem_to_reg;
  assign bus.ALUOp    = r_ctrl.alu_op;
  assign bus.MemWrite = r_ctrl.mem_write;
  assign bus.ALUSrc   = r_ctrl.alu_src;
  assign bus.RegWrite = r_ctrl.reg_write;

endmodule

// File: tb/tb_control_unity.sv
// Directed bench for control_unity: each task drives one scenario and checks against
// hand-computed control words {RegDst,Branch,MemRead,MemtoReg,ALUOp,MemWrite,ALUSrc,RegWrite}.
module tb_control_unity;

  localparam logic [8:0] ExpNop  = 9'b0_0_0_0_00_0_0_0;
  localparam logic [8:0] ExpR    = 9'b1_0_0_0_10_0_0_1;
  localparam logic [8:0] ExpAddi = 9'b0_0_0_0_00_0_1_1;
  localparam logic [8:0] ExpLw   = 9'b0_0_1_1_00_0_1_1;
  localparam logic [8:0] ExpSw   = 9'b0_0_0_0_00_1_1_0;
  localparam logic [8:0] ExpBeq  = 9'b0_1_0_0_01_0_0_0;
  localparam logic [8:0] ExpLogi = 9'b0_0_0_0_11_0_1_1;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  control_unity_if bus ();

  control_unity dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  wire [8:0] w_obs = {bus.RegDst, bus.Branch, bus.MemRead, bus.MemtoReg, bus.ALUOp,
                      bus.MemWrite, bus.ALUSrc, bus.RegWrite};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.opcode = 4'b0001;
    #1;
    n_checks++;
    if (w_obs !== ExpNop) begin
      n_fail++;
      $display("FAIL reset_immediate got=%b want=%b", w_obs, ExpNop);
    end
    repeat (3) step();
    n_checks++;
    if (w_obs !== ExpNop) begin
      n_fail++;
      $display("FAIL reset_held_clocked got=%b want=%b", w_obs, ExpNop);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== ExpNop) begin
      n_fail++;
      $display("FAIL reset_release_before_edge got=%b want=%b", w_obs, ExpNop);
    end
    step();
    n_checks++;
    if (w_obs !== ExpR) begin
      n_fail++;
      $display("FAIL reset_first_decode got=%b want=%b", w_obs, ExpR);
    end
  endtask

  task automatic test_rtype_sweep();
    logic [8:0] exp;
    for (int i = 0; i <= 5; i++) begin
      bus.opcode = 4'(i);
      exp = (i == 0) ? ExpNop : ExpR;
      step();
      n_checks++;
      if (w_obs !== exp) begin
        n_fail++;
        $display("FAIL rtype_sweep op=%0d got=%b want=%b", i, w_obs, exp);
      end
    end
  endtask

  task automatic test_memory_ops();
    bus.opcode = 4'b0111;
    step();
    n_checks++;
    if (w_obs !== ExpLw) begin
      n_fail++;
      $display("FAIL mem_lw got=%b want=%b", w_obs, ExpLw);
    end
    bus.opcode = 4'b1000;
    step();
    n_checks++;
    if (w_obs !== ExpSw) begin
      n_fail++;
      $display("FAIL mem_sw got=%b want=%b", w_obs, ExpSw);
    end
  endtask

  task automatic test_branch_imm();
    logic [3:0] ops [4];
    logic [8:0] exps [4];
    ops  = '{4'b1001, 4'b0110, 4'b1010, 4'b1011};
    exps = '{ExpBeq, ExpAddi, ExpLogi, ExpLogi};
    for (int i = 0; i < 4; i++) begin
      bus.opcode = ops[i];
      step();
      n_checks++;
      if (w_obs !== exps[i]) begin
        n_fail++;
        $display("FAIL branch_imm op=%b got=%b want=%b", ops[i], w_obs, exps[i]);
      end
    end
  endtask

  task automatic test_reserved();
    for (int i = 12; i <= 15; i++) begin
      // Precede each reserved opcode with LW so a stale decode cannot pass as NOP.
      bus.opcode = 4'b0111;
      step();
      bus.opcode = 4'(i);
      step();
      n_checks++;
      if (w_obs !== ExpNop) begin
        n_fail++;
        $display("FAIL reserved op=%0d got=%b want=%b", i, w_obs, ExpNop);
      end
    end
    bus.opcode = 4'b0001;
    step();
    bus.opcode = 4'bxxxx;
    step();
    n_checks++;
    if (w_obs !== ExpNop) begin
      n_fail++;
      $display("FAIL illegal_x got=%b want=%b", w_obs, ExpNop);
    end
  endtask

  task automatic test_back_to_back();
    bus.opcode = 4'b1001;
    step();
    // An opcode change between edges must not reach the outputs before the next edge.
    bus.opcode = 4'b0111;
    #2;
    n_checks++;
    if (w_obs !== ExpBeq) begin
      n_fail++;
      $display("FAIL hold_between_edges got=%b want=%b", w_obs, ExpBeq);
    end
    step();
    n_checks++;
    if (w_obs !== ExpLw) begin
      n_fail++;
      $display("FAIL back_to_back got=%b want=%b", w_obs, ExpLw);
    end
  endtask

  task automatic test_invariants();
    for (int i = 0; i < 200; i++) begin
      bus.opcode = 4'($urandom_range(0, 15));
      step();
      n_checks++;
      if (bus.MemRead && bus.MemWrite) begin
        n_fail++;
        $display("FAIL inv_rd_wr op=%b got=%b want=not_both", bus.opcode, w_obs);
      end
      n_checks++;
      if (bus.MemtoReg && !bus.MemRead) begin
        n_fail++;
        $display("FAIL inv_memtoreg op=%b got=%b want=memread", bus.opcode, w_obs);
      end
      n_checks++;
      if (bus.Branch && (bus.RegWrite || bus.MemWrite)) begin
        n_fail++;
        $display("FAIL inv_branch op=%b got=%b want=no_writes", bus.opcode, w_obs);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.opcode = 4'b0111;
    step();
    n_checks++;
    if (w_obs !== ExpLw) begin
      n_fail++;
      $display("FAIL async_pre_lw got=%b want=%b", w_obs, ExpLw);
    end
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== ExpNop) begin
      n_fail++;
      $display("FAIL async_clear got=%b want=%b", w_obs, ExpNop);
    end
    step();
    n_checks++;
    if (w_obs !== ExpNop) begin
      n_fail++;
      $display("FAIL async_held got=%b want=%b", w_obs, ExpNop);
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== ExpNop) begin
      n_fail++;
      $display("FAIL async_release_before_edge got=%b want=%b", w_obs, ExpNop);
    end
    step();
    n_checks++;
    if (w_obs !== ExpLw) begin
      n_fail++;
      $display("FAIL async_first_decode got=%b want=%b", w_obs, ExpLw);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_rtype_sweep();
    test_memory_ops();
    test_branch_imm();
    test_reserved();
    test_back_to_back();
    test_invariants();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unity.md
# control_unity

Main decoder of the 16-bit processor. It maps the 4-bit instruction opcode to the datapath control signals: register-destination select, branch, memory read/write, write-back select, ALU operation class, ALU operand select and register-file write enable. All outputs are registered, so the datapath sees the decoded controls one clock edge after the opcode is presented. Each decode depends only on the current opcode; the block keeps no instruction history.

## Interface
Parameters: none.

Clock and reset: one clock; reset is asynchronous and active-low.

- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low; clears every output register
- opcode  input  4  instruction opcode field
- RegDst  output  1  1 = destination register from the rd field (R-type); 0 = from the rt field
- Branch  output  1  1 = conditional branch (BEQ)
- MemRead  output  1  1 = data memory read
- MemtoReg  output  1  1 = write-back data from memory; 0 = from the ALU
- ALUOp  output  2  00 add (address or immediate), 01 subtract (compare), 10 R-type function decode, 11 logical immediate
- MemWrite  output  1  1 = data memory write
- ALUSrc  output  1  1 = second ALU operand is the sign-extended immediate; 0 = register
- RegWrite  output  1  1 = register file write enable

## Operation
Decode table. Signals not listed are 0.

- 0000 NOP: all outputs 0.
- 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 SLT (R-type): RegDst=1, ALUOp=10, RegWrite=1.
- 0110 ADDI: ALUSrc=1, ALUOp=00, RegWrite=1.
- 0111 LW: ALUSrc=1, MemRead=1, MemtoReg=1, ALUOp=00, RegWrite=1.
- 1000 SW: ALUSrc=1, MemWrite=1, ALUOp=00.
- 1001 BEQ: Branch=1, ALUOp=01.
- 1010 ANDI, 1011 ORI: ALUSrc=1, ALUOp=11, RegWrite=1.
- 1100–1111 reserved: decode exactly as NOP (all 0), so no register or memory side effects.
- An X or Z on opcode decodes as NOP.

Invariants that must hold for every opcode:
- MemRead and MemWrite are never both 1.
- MemtoReg=1 only when MemRead=1.
- Branch=1 implies RegWrite=0 and MemWrite=0.

## Timing
- Reset: while reset=0, all outputs are 0 (NOP pattern) immediately, independent of clock.
- Releasing reset: outputs stay 0 until the first rising clock edge with reset=1.
- Latency: on each rising edge with reset=1, the outputs take the decode of the opcode sampled at that edge. This is a 1-cycle latency from the opcode to the control signals.
- Between edges the outputs hold; opcode changes between edges have no effect.
- Reset asserted mid-operation: outputs clear within the same cycle, asynchronously. The next decode occurs at the first rising edge after reset deasserts.
- Back-to-back opcodes: every edge produces an independent decode; there are no multi-cycle states or stalls.
- No combinational path from opcode to any output.

## Test plan
- Reset: hold reset=0 with opcode=0001 and toggle the clock → all outputs 0. Release reset → at the first rising edge RegDst=1, ALUOp=10, RegWrite=1, all others 0.
- R-type and NOP sweep: opcode 0000 then 0001 through 0101, one per edge → 0000 gives all 0; each R-type gives RegDst=1, ALUOp=10, RegWrite=1, Branch=MemRead=MemWrite=MemtoReg=ALUSrc=0, each one edge after it is applied.
- Memory ops: opcode 0111 → ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=00. Then 1000 → ALUSrc=1, MemWrite=1, RegWrite=0, MemRead=0.
- Branch and immediates: 1001 → Branch=1, ALUOp=01, RegWrite=0. 0110 → ALUSrc=1, RegWrite=1, ALUOp=00. 1010 and 1011 → ALUSrc=1, RegWrite=1, ALUOp=11.
- Reserved and illegal: opcodes 1100–1111 and 4'bxxxx → all outputs 0. Check the three invariants after every edge of a random 200-opcode stream.
- Asynchronous reset mid-stream: opcode=0111 decoded (MemRead=1), then pull reset low between edges → all outputs 0 before the next edge; outputs stay 0 until the first edge after release.
